// File: rtl/status_reg_sched.sv
// Round-robin scheduler feeding one shared 32-bit status register: grants a requester,
// loads its word, holds it stable for HOLD_CYCLES cycles, then acknowledges.
module status_reg_sched #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                 OPB_Clk,
  input  logic                 OPB_Rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     ack,
  output logic [31:0]          user_data_out,
  output logic [1:0]           user_src,
  output logic                 busy,
  output logic [15:0]          update_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  grant;
  logic [1:0]  grant_nxt;
  logic [1:0]  last_grant;
  logic [7:0]  counter;
  logic        found;
  int          idx;

  // Round-robin search starting just above the last completed grant.
  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    grant_nxt = grant;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && req[idx]) begin
        grant_nxt = 2'(idx);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LOAD;
      LOAD:    state_nxt = HOLD;
      HOLD:    if (counter == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state         <= IDLE;
      grant         <= 2'd0;
      last_grant    <= 2'(N_REQ - 1);
      counter       <= 8'd0;
      ack           <= '0;
      user_data_out <= 32'd0;
      user_src      <= 2'd0;
      update_count  <= 16'd0;
    end else begin
      state <= state_nxt;
      ack   <= '0;
      case (state)
        IDLE: begin
          if (|req) grant <= grant_nxt;
        end
        LOAD: begin
          user_data_out <= req_data[32*int'(grant) +: 32];
          user_src      <= grant;
          counter       <= 8'(HOLD_CYCLES - 1);
        end
        HOLD: begin
          if (counter == 8'd0) begin
            // ack is registered, so it is seen during the first IDLE cycle after HOLD.
            ack          <= {{(N_REQ-1){1'b0}}, 1'b1} << grant;
            last_grant   <= grant;
            update_count <= update_count + 16'd1;
          end else begin
            counter <= counter - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_status_reg_sched.sv
// Self-checking bench for status_reg_sched: table vectors, corner-case sequences
// and randomized transactions against a transaction-level round-robin model.
module tb_status_reg_sched;

  localparam int N = 4;
  localparam int H = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [127:0]  req_data = '0;
  logic [N-1:0]  ack;
  logic [31:0]   user_data_out;
  logic [1:0]    user_src;
  logic          busy;
  logic [15:0]   update_count;

  status_reg_sched #(.N_REQ(N), .HOLD_CYCLES(H)) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .user_data_out (user_data_out),
    .user_src      (user_src),
    .busy          (busy),
    .update_count  (update_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  m_last = 2'd3;
  logic [15:0] m_cnt  = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requesting index after the last grant, wrapping.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] mask);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (int'(last) + k) % N;
      if (mask[i]) return 2'(i);
    end
    return last;
  endfunction

  always @(negedge clk) begin
    if (!rst) check("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
  end

  // Runs one full update starting at a negedge in IDLE. Leaves req driven unless dropped.
  task automatic do_update(input logic [3:0] mask, input logic [127:0] words, input bit keep,
                           input int exp_g, input string tag);
    logic [31:0] word;
    bit          hold_bad;
    word     = words[32*exp_g +: 32];
    hold_bad = 1'b0;
    check({tag, "_idle_before"}, 32'(busy), 32'd0);
    req      = mask;
    req_data = words;
    @(posedge clk); @(negedge clk);
    check({tag, "_load_busy"}, 32'(busy), 32'd1);
    if (!keep) req = '0;
    @(posedge clk); @(negedge clk);
    check({tag, "_data"}, user_data_out, word);
    check({tag, "_src"}, 32'(user_src), 32'(exp_g));
    req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 1; k < H; k++) begin
      @(posedge clk); @(negedge clk);
      if (ack !== '0 || busy !== 1'b1 || user_data_out !== word) hold_bad = 1'b1;
    end
    check({tag, "_hold_quiet"}, 32'(hold_bad), 32'd0);
    @(posedge clk); @(negedge clk);
    m_last = 2'(exp_g);
    m_cnt  = m_cnt + 16'd1;
    check({tag, "_ack"}, 32'(ack), 32'(4'b0001 << exp_g));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(update_count), 32'(m_cnt));
    check({tag, "_data_kept"}, user_data_out, word);
  endtask

  typedef struct {
    logic [3:0] mask;
    bit         keep;
    int         exp_src;
  } vec_t;

  vec_t         vecs[7];
  int           cont_exp[5];
  logic [127:0] base_words;
  logic [31:0]  held_data;
  logic [1:0]   held_src;

  initial begin
    vecs[0] = '{4'b0001, 1'b1, 0};
    vecs[1] = '{4'b1111, 1'b1, 1};
    vecs[2] = '{4'b0001, 1'b1, 0};
    vecs[3] = '{4'b1001, 1'b1, 3};
    vecs[4] = '{4'b1100, 1'b1, 2};
    vecs[5] = '{4'b0100, 1'b0, 2};
    vecs[6] = '{4'b1011, 1'b1, 3};
    cont_exp = '{0, 1, 2, 3, 0};
    base_words = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_data", user_data_out, 32'd0);
    check("rst_src", 32'(user_src), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(update_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, each followed by an idle cycle in which outputs must hold
    for (int v = 0; v < 7; v++) begin
      do_update(vecs[v].mask, base_words, vecs[v].keep, vecs[v].exp_src, $sformatf("vec%0d", v));
      req       = '0;
      held_data = user_data_out;
      held_src  = user_src;
      @(posedge clk); @(negedge clk);
      check($sformatf("vec%0d_idle_hold", v),
            32'(busy === 1'b0 && ack === '0 && user_data_out === held_data && user_src === held_src),
            32'd1);
    end

    // Contention: all four held, back-to-back grants rotate 0,1,2,3,0
    for (int c = 0; c < 5; c++)
      do_update(4'b1111, base_words, 1'b1, cont_exp[c], $sformatf("cont%0d", c));
    req = '0;
    @(posedge clk); @(negedge clk);

    // Reset mid-HOLD at counter value 5
    req      = 4'b1010;
    req_data = base_words;
    @(posedge clk); @(negedge clk);
    req = '0;
    @(posedge clk); @(negedge clk);
    repeat (10) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midrst_data", user_data_out, 32'd0);
    check("midrst_src", 32'(user_src), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(update_count), 32'd0);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("midrst_no_ack", 32'(ack), 32'd0);
    end
    rst    = 1'b0;
    m_last = 2'd3;
    m_cnt  = 16'd0;
    @(negedge clk);
    do_update(4'b0110, base_words, 1'b1, 1, "post_rst");
    req = '0;
    @(posedge clk); @(negedge clk);

    // Counter wrap
    force dut.update_count = 16'hFFFF;
    #1;
    release dut.update_count;
    m_cnt = 16'hFFFF;
    do_update(4'b0100, base_words, 1'b1, int'(rr_pick(m_last, 4'b0100)), "wrap");
    check("wrap_zero", 32'(update_count), 32'd0);
    req = '0;
    @(posedge clk); @(negedge clk);

    // Randomized transactions against the model
    for (int r = 0; r < 40; r++) begin
      logic [3:0]   mask;
      logic [127:0] words;
      bit           keep;
      mask  = 4'($urandom_range(1, 15));
      keep  = 1'($urandom_range(0, 1));
      words = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_update(mask, words, keep, int'(rr_pick(m_last, mask)), $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) begin
        req = '0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); @(negedge clk);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/status_reg_sched.md
STATUS_REG_SCHED -- requirements
Module: status_reg_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one software-readable status register (range 2..4).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, number of OPB_Clk cycles each value is held stable before the next update (range 1..255).
REQ-003 SHALL have port OPB_Clk  input  1  sole clock; all logic rises on it.
REQ-004 SHALL have port OPB_Rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ  per-requester update request, level.
REQ-006 SHALL have port req_data  input  32*N_REQ  requester i's word on bits [32i+31:32i].
REQ-007 SHALL have port ack  output  N_REQ  one-cycle completion pulse per requester.
REQ-008 SHALL have port user_data_out  output  32  word driven to the status register's user_data_in.
REQ-009 SHALL have port user_src  output  2  index of the requester whose word is on user_data_out.
REQ-010 SHALL have port busy  output  1  high in LOAD and HOLD.
REQ-011 SHALL have port update_count  output  16  count of completed updates.

Function
REQ-012 SHALL implement states IDLE, LOAD and HOLD, encoded freely.
REQ-013 In IDLE with any req bit high, SHALL grant round-robin, searching from last_grant+1 upward with wrap, and go to LOAD on the same edge.
REQ-014 In IDLE with req all zero, SHALL stay in IDLE and hold all outputs.
REQ-015 In LOAD, SHALL register req_data of the granted requester into user_data_out, write the grant index to user_src, load hold counter with HOLD_CYCLES-1, and go to HOLD; LOAD lasts exactly 1 cycle.
REQ-016 In HOLD, SHALL decrement the counter each cycle; on the cycle the counter is 0, SHALL assert ack[grant] for that single cycle, set last_grant=grant, increment update_count, and return to IDLE.
REQ-017 Latency: req sampled high in IDLE at edge t -> user_data_out valid after edge t+1 -> ack high during cycle following edge t+1+HOLD_CYCLES.
REQ-018 user_data_out and user_src SHALL remain constant from LOAD until the next LOAD, including across IDLE.
REQ-019 req_data changes after LOAD SHALL NOT affect user_data_out.
REQ-020 req SHALL be sampled only in IDLE; req dropping during HOLD SHALL NOT abort; ack still pulses.
REQ-021 A requester holding req through ack SHALL be re-eligible but lower priority than the others on the next grant.
REQ-022 Back-to-back grants SHALL be spaced HOLD_CYCLES+2 cycles (one IDLE cycle between).
REQ-023 At most one ack bit SHALL be high in any cycle.
REQ-024 update_count SHALL wrap 0xFFFF -> 0x0000 without saturation.
REQ-025 Requester indices >= N_REQ SHALL never be granted.

Reset
REQ-026 OPB_Rst high SHALL immediately force state IDLE, ack=0, user_data_out=0, user_src=0, busy=0, update_count=0, counter=0, last_grant=N_REQ-1 (requester 0 highest priority first).
REQ-027 Reset asserted mid-HOLD SHALL abort the update with no ack pulse and no update_count increment.
REQ-028 After reset release, first grant SHALL occur no earlier than the first rising edge with OPB_Rst low.

Verification
REQ-029 Single: req=0001, req_data[31:0]=0xDEADBEEF, HOLD_CYCLES=16 -> user_data_out=0xDEADBEEF, user_src=0 after 2 edges; ack=0001 for 1 cycle 16 cycles later; update_count=1.
REQ-030 Contention: req=1111 held -> grants in order 0,1,2,3,0, ack pulses spaced 18 cycles, never two bits high.
REQ-031 Data stability: change req_data[0] to 0x12345678 during HOLD -> user_data_out stays 0xDEADBEEF until next LOAD.
REQ-032 Early drop: req[2] pulsed 1 cycle in IDLE -> full update completes, ack[2] pulses, busy low afterward.
REQ-033 Reset mid-HOLD: assert OPB_Rst at HOLD count 5 -> all outputs 0 asynchronously, no ack; next grant goes to lowest pending index.
REQ-034 Wrap: preload 65535 updates (or force update_count=0xFFFF) -> next ack yields update_count=0x0000.
